main_mem_ctrl: RTL
==================

MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 Parameter WORD_W, default 32: data word width in bits (multiple of 8).
REQ-002 Parameter LINE_WORDS, default 16: words per cache line (power of two).
REQ-003 Parameter DEPTH_WORDS, default 4096: storage depth in words (power of two, multiple of LINE_WORDS).
REQ-004 Parameter READ_LAT, default 4: wait cycles for a read (minimum 1).
REQ-005 Parameter WRITE_LAT, default 4: wait cycles for a write (minimum 1).
REQ-006 Parameter ALIAS, default 1: 1 = addresses wrap modulo storage size; 0 = out-of-range access flagged as an error.
REQ-007 Parameter INIT_VAL, default all ones: initial value of every storage word.
REQ-008 clk  input  1  single clock, rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 main_mem_addr  input  32  byte address of the request.
REQ-011 main_mem_read_req  input  1  level request for a line read.
REQ-012 main_mem_write_req  input  1  level request for a write.
REQ-013 main_mem_line_wr  input  1  write mode, sampled with write_req: 1 = full-line write, 0 = single-word write.
REQ-014 main_mem_data_out  input  WORD_W  single-word write data.
REQ-015 main_mem_line_data_out  input  LINE_WORDS*WORD_W  full-line write data; word i occupies bits [i*WORD_W +: WORD_W].
REQ-016 main_mem_data_in  output  LINE_WORDS*WORD_W  returned read line, same word packing as REQ-015.
REQ-017 main_mem_ready  output  1  one-cycle completion pulse.
REQ-018 main_mem_err  output  1  error flag, valid only while main_mem_ready is high.
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have four states: IDLE, READ_WAIT, WRITE_WAIT and DONE.
REQ-021 In IDLE, a rising edge with read_req=1 SHALL capture the address and go to READ_WAIT; read_req takes priority when both requests are high.
REQ-022 In IDLE, a rising edge with write_req=1 and read_req=0 SHALL capture the address, line_wr and the write data, then go to WRITE_WAIT.
REQ-023 Requests SHALL be ignored in every state other than IDLE; a non-serviced request is dropped and is not queued.
REQ-024 Each wait state SHALL last exactly READ_LAT or WRITE_LAT cycles, then move to DONE.
REQ-025 DONE SHALL last one cycle with main_mem_ready=1, then return to IDLE; if a request accepted at edge N, ready is high in the cycle after edge N+LAT.
REQ-026 The requester SHALL deassert its request in the ready cycle; a request still high at the following edge is accepted as a new request.
REQ-027 Byte-to-word index: addr >> log2(WORD_W/8); sub-word address bits SHALL be ignored.
REQ-028 Line base address: word index with the low log2(LINE_WORDS) bits cleared.
REQ-029 A read SHALL load main_mem_data_in with the LINE_WORDS words starting at the line base, on the edge entering DONE.
REQ-030 main_mem_data_in SHALL hold its value until the next read completes.
REQ-031 A single-word write SHALL update one word; a line write SHALL update all LINE_WORDS words at the line base.
REQ-032 Storage SHALL be committed on the edge entering DONE, and never earlier.
REQ-033 ALIAS=1: the word index SHALL be taken modulo DEPTH_WORDS.
REQ-034 ALIAS=0: an address at or above DEPTH_WORDS*WORD_W/8 SHALL cause no storage access, SHALL leave data_in unchanged, and SHALL pulse err with ready.
REQ-035 Storage SHALL initialise to INIT_VAL at time zero and SHALL NOT be altered by rst_n.

Reset
REQ-036 While rst_n=0: state=IDLE, main_mem_ready=0, main_mem_err=0, busy=0, main_mem_data_in=0, and all wait counters cleared.
REQ-037 Reset asserted during any wait state SHALL discard the operation: no storage update and no ready pulse.

Verification
REQ-038 Read 0x00000040 accepted at edge N (defaults) -> ready high only in the cycle after edge N+4; data_in = 16 x FFFFFFFF; err=0.
REQ-039 Word write 0x00000046 data DEADBEEF, then read 0x00000040 -> bits[63:32]=DEADBEEF; all other words FFFFFFFF.
REQ-040 Line write 0x0000009C with word i = i, then read 0x00000080 -> word i = i for i = 0..15.
REQ-041 ALIAS=1: write 0x00004044 data 12345678, then read 0x00000040 -> word1 = 12345678. ALIAS=0: same write -> ready with err=1; a subsequent read of 0x00000040 returns word1 = FFFFFFFF.
REQ-042 read_req and write_req high together, both dropped at ready -> only the read is serviced and storage is unchanged; a request held through the ready cycle -> serviced a second time.
REQ-043 rst_n pulsed low during WRITE_WAIT of a write of 0x00000000 with data 0 -> no ready pulse; a later read of 0x00000000 returns word0 = FFFFFFFF. READ_LAT=1 -> ready high in the cycle after edge N+1.

Source files
------------

// File: rtl/main_mem_ctrl_if.sv
// ============================================================================
//  Module   : main_mem_ctrl_if
//  Purpose  : Request/response bundle between a cache-side requester and the
//             main memory controller.
//  Ports    : main_mem_addr          byte address of the request
//             main_mem_read_req      level request, line read
//             main_mem_write_req     level request, write
//             main_mem_line_wr       1 = full-line write, 0 = single word
//             main_mem_data_out      single-word write data
//             main_mem_line_data_out full-line write data (word i at i*WORD_W)
//             main_mem_data_in       returned read line (same packing)
//             main_mem_ready         one-cycle completion pulse
//             main_mem_err           error flag, valid with ready
//  Modports : master (requester side), slave (controller side)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface main_mem_ctrl_if #(
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 16
);
    logic [31:0]                  main_mem_addr;
    logic                         main_mem_read_req;
    logic                         main_mem_write_req;
    logic                         main_mem_line_wr;
    logic [WORD_W-1:0]            main_mem_data_out;
    logic [LINE_WORDS*WORD_W-1:0] main_mem_line_data_out;
    logic [LINE_WORDS*WORD_W-1:0] main_mem_data_in;
    logic                         main_mem_ready;
    logic                         main_mem_err;

    modport master (
        output main_mem_addr,
        output main_mem_read_req,
        output main_mem_write_req,
        output main_mem_line_wr,
        output main_mem_data_out,
        output main_mem_line_data_out,
        input  main_mem_data_in,
        input  main_mem_ready,
        input  main_mem_err
    );

    modport slave (
        input  main_mem_addr,
        input  main_mem_read_req,
        input  main_mem_write_req,
        input  main_mem_line_wr,
        input  main_mem_data_out,
        input  main_mem_line_data_out,
        output main_mem_data_in,
        output main_mem_ready,
        output main_mem_err
    );
endinterface

`default_nettype wire

// File: rtl/main_mem_ctrl.sv
// ============================================================================
//  Module   : main_mem_ctrl
//  Purpose  : Behavioural main-memory model with fixed read/write latency.
//             Services one request at a time: line reads, single-word writes
//             and full-line writes. Requests arriving while busy are dropped.
//  Ports    : clk    single clock, rising edge
//             rst_n  asynchronous active-low reset (storage is not reset)
//             bus    main_mem_ctrl_if.slave request/response bundle
//             busy   high whenever the controller is not idle
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_mem_ctrl #(
    parameter int               WORD_W      = 32,
    parameter int               LINE_WORDS  = 16,
    parameter int               DEPTH_WORDS = 4096,
    parameter int               READ_LAT    = 4,
    parameter int               WRITE_LAT   = 4,
    parameter int               ALIAS       = 1,
    parameter logic [WORD_W-1:0] INIT_VAL   = '1
) (
    input  logic            clk,
    input  logic            rst_n,
    main_mem_ctrl_if.slave  bus,
    output logic            busy
);

    localparam int c_LINE_BITS = LINE_WORDS * WORD_W;
    localparam int c_BYTE_SH   = $clog2(WORD_W / 8);
    localparam int c_AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int c_LAT_MAX   = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int c_CNT_W     = (c_LAT_MAX > 1) ? $clog2(c_LAT_MAX) : 1;

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_READ_WAIT  = 2'd1;
    localparam logic [1:0] c_WRITE_WAIT = 2'd2;
    localparam logic [1:0] c_DONE       = 2'd3;

    localparam logic [c_AW-1:0] c_LINE_MASK = c_AW'(LINE_WORDS - 1);

    // Storage powers up to INIT_VAL and is deliberately outside the reset
    // domain: a reset must never disturb memory contents.
    logic [WORD_W-1:0]      r_mem [DEPTH_WORDS] = '{default: INIT_VAL};

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [31:0]            r_addr;
    logic                   r_line_wr;
    logic [WORD_W-1:0]      r_wdata;
    logic [c_LINE_BITS-1:0] r_line_data;
    logic [c_LINE_BITS-1:0] r_data_in;
    logic                   r_err;

    logic [31:0]            w_word_idx;
    logic                   w_oob;
    logic [c_AW-1:0]        w_widx;
    logic [c_AW-1:0]        w_base;
    logic                   w_last;
    logic                   w_commit_wr;
    logic                   w_load_rd;

    // Byte address -> word index; sub-word bits fall off in the shift.
    assign w_word_idx = r_addr >> c_BYTE_SH;
    // With aliasing enabled the truncation to c_AW bits is the modulo.
    assign w_oob      = (ALIAS == 0) && (w_word_idx >= 32'(DEPTH_WORDS));
    assign w_widx     = w_word_idx[c_AW-1:0];
    assign w_base     = w_widx & ~c_LINE_MASK;

    // The counter is loaded with LAT-1 on acceptance, so reaching zero marks
    // the final wait cycle and the following edge enters DONE.
    assign w_last      = (r_cnt == '0);
    assign w_commit_wr = (r_state == c_WRITE_WAIT) && w_last && !w_oob;
    assign w_load_rd   = (r_state == c_READ_WAIT)  && w_last && !w_oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_line_wr   <= 1'b0;
            r_wdata     <= '0;
            r_line_data <= '0;
            r_data_in   <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // Read wins when both requests are raised together.
                    if (bus.main_mem_read_req) begin
                        r_addr  <= bus.main_mem_addr;
                        r_cnt   <= c_CNT_W'(READ_LAT - 1);
                        r_state <= c_READ_WAIT;
                    end else if (bus.main_mem_write_req) begin
                        r_addr      <= bus.main_mem_addr;
                        r_line_wr   <= bus.main_mem_line_wr;
                        r_wdata     <= bus.main_mem_data_out;
                        r_line_data <= bus.main_mem_line_data_out;
                        r_cnt       <= c_CNT_W'(WRITE_LAT - 1);
                        r_state     <= c_WRITE_WAIT;
                    end
                end
                c_READ_WAIT, c_WRITE_WAIT: begin
                    if (w_last) begin
                        r_state <= c_DONE;
                        r_err   <= w_oob;
                        if (w_load_rd) begin
                            for (int i = 0; i < LINE_WORDS; i++) begin
                                r_data_in[i*WORD_W +: WORD_W] <= r_mem[w_base + c_AW'(i)];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // Commit happens on the same edge that enters DONE. An asynchronous reset
    // during the wait forces IDLE immediately, so the commit never fires.
    always_ff @(posedge clk) begin
        if (w_commit_wr) begin
            if (r_line_wr) begin
                for (int i = 0; i < LINE_WORDS; i++) begin
                    r_mem[w_base + c_AW'(i)] <= r_line_data[i*WORD_W +: WORD_W];
                end
            end else begin
                r_mem[w_widx] <= r_wdata;
            end
        end
    end

    assign bus.main_mem_data_in = r_data_in;
    assign bus.main_mem_ready   = (r_state == c_DONE);
    assign bus.main_mem_err     = r_err;
    assign busy                 = (r_state != c_IDLE);

endmodule

`default_nettype wire
